lpif_link_online_ctrl: RTL and testbench
========================================

Name: lpif_link_online_ctrl

Overview:
- Bring-up and retrain sequencer for the x8 LPIF TX/RX datapath.
- Drives tx_online and rx_online into the auto-sync/concat path, in order, from per-channel PHY readiness and channel-alignment status.
- Times the TX settle window and the alignment timeout, and forces a retrain on alignment loss, PHY drop or software request.
- Exports link state, a sticky timeout error and a saturating retrain count for status registers.

Parameters:
- NUM_CH, 8: number of PHY channels whose ready bits are ANDed.
- TMR_W, 16: width of the alignment timeout timer.
- RETRAIN_HOLD, 4: cycles all online outputs are held low in RETRAIN (minimum 1).

Ports:
- clk_wr  in  1  single clock.
- rst_wr  in  1  asynchronous, active-high reset.
- link_en  in  1  software enable; 0 forces IDLE.
- phy_ready  in  NUM_CH  per-channel PHY ready, synchronous to clk_wr.
- align_done  in  1  channel alignment complete, synchronous to clk_wr.
- retrain_req  in  1  single-cycle software retrain request.
- clr_err  in  1  clears timeout_err.
- tx_settle_cycles  in  8  TX settle window length, in cycles.
- align_timeout  in  TMR_W  alignment wait limit, in cycles; 0 disables the timeout.
- tx_online  out  1  TX online to the datapath.
- rx_online  out  1  RX online to the datapath.
- link_up  out  1  link is in ACTIVE.
- link_state  out  3  current FSM state encoding.
- timeout_err  out  1  sticky alignment timeout.
- retrain_cnt  out  8  saturating count of retrains entered from ACTIVE.

Behaviour:
- All outputs are registered. Reset value of every output is 0; reset enters IDLE with timer = 0.
- FSM encoding: IDLE=0, PHY_WAIT=1, TX_SETTLE=2, ALIGN_WAIT=3, ACTIVE=4, RETRAIN=5. Codes 6 and 7 are illegal and go to IDLE on the next cycle.
- Global priority, evaluated every cycle:
  1. link_en=0 -> IDLE from any state, with all online outputs low on the next cycle.
  2. Any phy_ready bit low while in TX_SETTLE, ALIGN_WAIT or ACTIVE -> RETRAIN.
  3. State-specific transitions below.
- IDLE: link_en=1 -> PHY_WAIT.
- PHY_WAIT: when every phy_ready bit is 1 -> TX_SETTLE; timer loads tx_settle_cycles.
- TX_SETTLE: tx_online=1. Timer decrements each cycle; at timer=0 -> ALIGN_WAIT, timer loads align_timeout. tx_settle_cycles=0 gives exactly one cycle in TX_SETTLE.
- ALIGN_WAIT:
  - tx_online=1.
  - align_done=1 -> ACTIVE.
  - Otherwise, if align_timeout!=0, timer decrements; at timer=0 -> set timeout_err and go to RETRAIN.
  - align_done=1 in the same cycle the timer expires: ACTIVE wins, no error.
- ACTIVE:
  - tx_online=1, rx_online=1, link_up=1.
  - align_done=0 or retrain_req=1 -> RETRAIN, and retrain_cnt increments, saturating at 255.
- RETRAIN: all online outputs 0. Hold counter runs RETRAIN_HOLD cycles, then -> PHY_WAIT. retrain_req outside ACTIVE is ignored.
- rx_online never asserts before tx_online has been high for at least tx_settle_cycles+2 cycles.
- In any state, the online outputs are low on the cycle after leaving ACTIVE.
- Latency: the rx_online rising edge is registered one cycle after the cycle in which align_done is sampled high in ALIGN_WAIT.
- timeout_err: set by a timeout, cleared by clr_err. Set and clear in the same cycle leaves it set. Not cleared by link_en.
- retrain_cnt: cleared only by reset. Timeouts in ALIGN_WAIT do not increment it.
- Asserting rst_wr mid-operation clears all outputs asynchronously, regardless of state.

Test Plan:
- Basic bring-up: reset, link_en=1, all phy_ready=1, tx_settle_cycles=3, align_done rises 5 cycles after tx_online -> tx_online high, rx_online/link_up high exactly 1 cycle after align_done is sampled, link_state=4.
- Timeout: align_timeout=10, align_done held 0 -> timeout_err=1 after 10 cycles in ALIGN_WAIT, RETRAIN for 4 cycles, back to PHY_WAIT. retrain_cnt stays 0. clr_err=1 clears timeout_err.
- Alignment loss in ACTIVE: drop align_done -> online outputs low next cycle, retrain_cnt 0->1, re-reach ACTIVE after re-alignment. Repeat 300 times -> retrain_cnt saturates at 255.
- Priority: in ACTIVE, pulse phy_ready[5]=0 together with retrain_req -> single RETRAIN entry, retrain_cnt +1. Then link_en=0 while in RETRAIN -> IDLE, all outputs 0.
- Boundaries: tx_settle_cycles=0 -> TX_SETTLE lasts 1 cycle. align_timeout=0 with align_done held 0 for 70000 cycles -> no timeout. align_done rising on the timer-expiry cycle -> ACTIVE, timeout_err=0.
- Async reset: assert rst_wr mid-cycle while in ACTIVE -> all outputs 0 immediately, link_state=0, retrain_cnt=0.

Source files
------------

// File: rtl/lpif_link_online_ctrl_if.sv
// LPIF link online controller status/control bundle.
// Software control and PHY status in, online/status out.
interface lpif_link_online_ctrl_if #(
   parameter int NUM_CH = 8,
   parameter int TMR_W  = 16
);
   logic              link_en;
   logic [NUM_CH-1:0] phy_ready;
   logic              align_done;
   logic              retrain_req;
   logic              clr_err;
   logic [7:0]        tx_settle_cycles;
   logic [TMR_W-1:0]  align_timeout;
   logic              tx_online;
   logic              rx_online;
   logic              link_up;
   logic [2:0]        link_state;
   logic              timeout_err;
   logic [7:0]        retrain_cnt;

   modport master (
      output link_en, phy_ready, align_done, retrain_req,
      output clr_err, tx_settle_cycles, align_timeout,
      input  tx_online, rx_online, link_up, link_state,
      input  timeout_err, retrain_cnt
   );

   modport slave (
      input  link_en, phy_ready, align_done, retrain_req,
      input  clr_err, tx_settle_cycles, align_timeout,
      output tx_online, rx_online, link_up, link_state,
      output timeout_err, retrain_cnt
   );
endinterface

// File: rtl/lpif_link_online_ctrl.sv
// Bring-up / retrain sequencer for the x8 LPIF TX/RX datapath.
// Orders tx_online before rx_online and tracks link status.
module lpif_link_online_ctrl #(
   parameter int NUM_CH       = 8,
   parameter int TMR_W        = 16,
   parameter int RETRAIN_HOLD = 4
) (
   input logic clk_wr,
   input logic rst_wr,
   lpif_link_online_ctrl_if.slave bus
);
   typedef enum logic [2:0] {
      IDLE       = 3'd0,
      PHY_WAIT   = 3'd1,
      TX_SETTLE  = 3'd2,
      ALIGN_WAIT = 3'd3,
      ACTIVE     = 3'd4,
      RETRAIN    = 3'd5
   } state_e;

   // Hold timer counts down to 0, so load one less than the hold length.
   localparam int HOLD_M1 = (RETRAIN_HOLD > 1) ? RETRAIN_HOLD - 1 : 0;
   localparam logic [TMR_W-1:0] HOLD_LD = HOLD_M1[TMR_W-1:0];

   state_e           state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             tx_q, rx_q, up_q;
   logic             err_q, err_set;
   logic [7:0]       cnt_q;
   logic             cnt_inc;
   logic             all_rdy;

   assign all_rdy = &bus.phy_ready;

   // Next state and timer: enable, then PHY drop, then per-state rules.
   always_comb begin
      state_d = state_q;
      tmr_d   = tmr_q;
      err_set = 1'b0;
      if (!bus.link_en) begin
         state_d = IDLE;
         tmr_d   = '0;
      end else if (!all_rdy &&
                   (state_q inside {TX_SETTLE, ALIGN_WAIT, ACTIVE})) begin
         state_d = RETRAIN;
         tmr_d   = HOLD_LD;
      end else begin
         case (state_q)
            IDLE: begin
               state_d = PHY_WAIT;
            end
            PHY_WAIT: begin
               if (all_rdy) begin
                  state_d = TX_SETTLE;
                  tmr_d   = TMR_W'(bus.tx_settle_cycles);
               end
            end
            TX_SETTLE: begin
               if (tmr_q == '0) begin
                  state_d = ALIGN_WAIT;
                  tmr_d   = bus.align_timeout;
               end else begin
                  tmr_d = tmr_q - 1'b1;
               end
            end
            ALIGN_WAIT: begin
               if (bus.align_done) begin
                  state_d = ACTIVE;
               end else if (bus.align_timeout != '0) begin
                  if (tmr_q == '0) begin
                     err_set = 1'b1;
                     state_d = RETRAIN;
                     tmr_d   = HOLD_LD;
                  end else begin
                     tmr_d = tmr_q - 1'b1;
                  end
               end
            end
            ACTIVE: begin
               if (!bus.align_done || bus.retrain_req) begin
                  state_d = RETRAIN;
                  tmr_d   = HOLD_LD;
               end
            end
            RETRAIN: begin
               if (tmr_q == '0) begin
                  state_d = PHY_WAIT;
               end else begin
                  tmr_d = tmr_q - 1'b1;
               end
            end
            default: begin
               state_d = IDLE;
               tmr_d   = '0;
            end
         endcase
      end
   end

   assign cnt_inc = (state_q == ACTIVE) && (state_d == RETRAIN) &&
                    (cnt_q != 8'hFF);

   // State and timer registers.
   always_ff @(posedge clk_wr or posedge rst_wr) begin
      if (rst_wr) begin
         state_q <= IDLE;
         tmr_q   <= '0;
      end else begin
         state_q <= state_d;
         tmr_q   <= tmr_d;
      end
   end

   // Online outputs follow the next state so they line up with it.
   always_ff @(posedge clk_wr or posedge rst_wr) begin
      if (rst_wr) begin
         tx_q <= 1'b0;
         rx_q <= 1'b0;
         up_q <= 1'b0;
      end else begin
         tx_q <= state_d inside {TX_SETTLE, ALIGN_WAIT, ACTIVE};
         rx_q <= (state_d == ACTIVE);
         up_q <= (state_d == ACTIVE);
      end
   end

   // Sticky timeout error (set wins over clear) and retrain counter.
   always_ff @(posedge clk_wr or posedge rst_wr) begin
      if (rst_wr) begin
         err_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         err_q <= err_set | (err_q & ~bus.clr_err);
         if (cnt_inc) cnt_q <= cnt_q + 8'd1;
      end
   end

   assign bus.tx_online   = tx_q;
   assign bus.rx_online   = rx_q;
   assign bus.link_up     = up_q;
   assign bus.link_state  = state_q;
   assign bus.timeout_err = err_q;
   assign bus.retrain_cnt = cnt_q;
endmodule

// File: tb/tb_lpif_link_online_ctrl.sv
// Directed bench for lpif_link_online_ctrl: vector table plus
// hand-written timeout, priority, saturation and reset sequences.
module tb_lpif_link_online_ctrl;
   logic clk_wr;
   logic rst_wr;
   int   checks;
   int   errors;
   int   exp_cnt;
   int   bad;

   lpif_link_online_ctrl_if #(.NUM_CH(8), .TMR_W(16)) bus ();

   lpif_link_online_ctrl #(
      .NUM_CH(8), .TMR_W(16), .RETRAIN_HOLD(4)
   ) dut (
      .clk_wr(clk_wr),
      .rst_wr(rst_wr),
      .bus(bus)
   );

   initial clk_wr = 1'b0;
   always #5 clk_wr = ~clk_wr;

   typedef struct {
      logic       en;
      logic [7:0] rdy;
      logic       ad;
      logic       rq;
      logic [2:0] st;
      logic       tx;
      logic       rx;
      logic [7:0] cnt;
   } vec_t;

   localparam int NV = 30;
   vec_t tv [NV];

   task automatic step();
      @(posedge clk_wr);
      #1;
   endtask

   task automatic chk(input string nm, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic wait_state(input logic [2:0] s, input int lim,
                             input string nm);
      int n;
      n = 0;
      while (bus.link_state != s && n < lim) begin
         step();
         n++;
      end
      chk(nm, 32'(bus.link_state), 32'(s));
   endtask

   task automatic do_steps(input int n, input logic [2:0] s,
                           input string nm);
      bad = 0;
      for (int i = 0; i < n; i++) begin
         step();
         if (bus.link_state != s || bus.timeout_err !== 1'b0) bad++;
      end
      chk(nm, 32'(bad), 32'd0);
   endtask

   initial begin
      checks  = 0;
      errors  = 0;
      exp_cnt = 0;
      bad     = 0;
      // en, rdy, ad, rq -> state, tx, rx(=link_up), cnt
      tv[0]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd0};
      tv[1]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'd0};
      tv[2]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'd0};
      tv[3]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'd0};
      tv[4]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'd0};
      tv[5]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 8'd0};
      tv[6]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 8'd0};
      tv[7]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 8'd0};
      tv[8]  = '{1'b1, 8'hFF, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 8'd0};
      tv[9]  = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 8'd1};
      tv[10] = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 8'd1};
      tv[11] = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 8'd1};
      tv[12] = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd5, 1'b0, 1'b0, 8'd1};
      tv[13] = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd1};
      tv[14] = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'd1};
      tv[15] = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'd1};
      tv[16] = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'd1};
      tv[17] = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'd1};
      tv[18] = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd3, 1'b1, 1'b0, 8'd1};
      tv[19] = '{1'b1, 8'hFF, 1'b1, 1'b0, 3'd4, 1'b1, 1'b1, 8'd1};
      tv[20] = '{1'b1, 8'hFF, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'd2};
      tv[21] = '{1'b1, 8'hFF, 1'b1, 1'b1, 3'd5, 1'b0, 1'b0, 8'd2};
      tv[22] = '{1'b1, 8'hFF, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 8'd2};
      tv[23] = '{1'b1, 8'hFF, 1'b1, 1'b0, 3'd5, 1'b0, 1'b0, 8'd2};
      tv[24] = '{1'b1, 8'hFF, 1'b1, 1'b0, 3'd1, 1'b0, 1'b0, 8'd2};
      tv[25] = '{1'b0, 8'hFF, 1'b1, 1'b0, 3'd0, 1'b0, 1'b0, 8'd2};
      tv[26] = '{1'b1, 8'h7F, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd2};
      tv[27] = '{1'b1, 8'h7F, 1'b0, 1'b0, 3'd1, 1'b0, 1'b0, 8'd2};
      tv[28] = '{1'b1, 8'hFF, 1'b0, 1'b0, 3'd2, 1'b1, 1'b0, 8'd2};
      tv[29] = '{1'b0, 8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 1'b0, 8'd2};

      rst_wr               = 1'b1;
      bus.link_en          = 1'b0;
      bus.phy_ready        = 8'hFF;
      bus.align_done       = 1'b0;
      bus.retrain_req      = 1'b0;
      bus.clr_err          = 1'b0;
      bus.tx_settle_cycles = 8'd3;
      bus.align_timeout    = 16'd0;
      repeat (2) step();

      chk("rst_flags",
          32'({bus.link_state, bus.tx_online, bus.rx_online,
               bus.link_up, bus.timeout_err}), 32'd0);
      chk("rst_cnt", 32'(bus.retrain_cnt), 32'd0);
      rst_wr = 1'b0;

      for (int i = 0; i < NV; i++) begin
         bus.link_en     = tv[i].en;
         bus.phy_ready   = tv[i].rdy;
         bus.align_done  = tv[i].ad;
         bus.retrain_req = tv[i].rq;
         step();
         chk($sformatf("vec%0d_flags", i),
             32'({bus.link_state, bus.tx_online, bus.rx_online,
                  bus.link_up, bus.timeout_err}),
             32'({tv[i].st, tv[i].tx, tv[i].rx, tv[i].rx, 1'b0}));
         chk($sformatf("vec%0d_cnt", i),
             32'(bus.retrain_cnt), 32'(tv[i].cnt));
      end
      exp_cnt = 2;
      bus.retrain_req = 1'b0;

      // Timeout with a zero-length settle window.
      bus.tx_settle_cycles = 8'd0;
      bus.align_timeout    = 16'd10;
      bus.align_done       = 1'b0;
      bus.link_en          = 1'b1;
      step();
      chk("to_phy_wait", 32'(bus.link_state), 32'd1);
      step();
      chk("settle0_enter",
          32'({bus.link_state, bus.tx_online}), 32'({3'd2, 1'b1}));
      step();
      chk("settle0_one_cycle", 32'(bus.link_state), 32'd3);
      do_steps(10, 3'd3, "to_wait_10");
      step();
      chk("to_expire",
          32'({bus.link_state, bus.tx_online, bus.timeout_err}),
          32'({3'd5, 1'b0, 1'b1}));
      do_steps(0, 3'd5, "noop");
      bad = 0;
      for (int i = 0; i < 3; i++) begin
         step();
         if (bus.link_state != 3'd5) bad++;
      end
      chk("to_hold4", 32'(bad), 32'd0);
      step();
      chk("to_back_phy", 32'(bus.link_state), 32'd1);
      chk("to_no_cnt", 32'(bus.retrain_cnt), 32'(exp_cnt));
      chk("to_err_held", 32'(bus.timeout_err), 32'd1);
      bus.clr_err = 1'b1;
      bus.link_en = 1'b0;
      step();
      chk("clr_err", 32'(bus.timeout_err), 32'd0);

      // Second timeout with clr_err held: set must win on expiry.
      bus.link_en = 1'b1;
      step();
      step();
      step();
      chk("to2_align", 32'(bus.link_state), 32'd3);
      for (int i = 0; i < 10; i++) step();
      step();
      chk("set_wins_clr",
          32'({bus.link_state, bus.timeout_err}), 32'({3'd5, 1'b1}));
      step();
      chk("clr_after_set", 32'(bus.timeout_err), 32'd0);
      bus.clr_err = 1'b0;
      bus.link_en = 1'b0;
      step();
      chk("en_off_idle", 32'(bus.link_state), 32'd0);

      // align_done arrives on the timer-expiry cycle.
      bus.link_en = 1'b1;
      step();
      step();
      step();
      chk("col_align", 32'(bus.link_state), 32'd3);
      for (int i = 0; i < 10; i++) step();
      chk("col_pre", 32'(bus.link_state), 32'd3);
      bus.align_done = 1'b1;
      step();
      chk("col_active",
          32'({bus.link_state, bus.rx_online, bus.timeout_err}),
          32'({3'd4, 1'b1, 1'b0}));

      // PHY drop and retrain request together: one retrain entry.
      bus.phy_ready   = 8'hDF;
      bus.retrain_req = 1'b1;
      step();
      exp_cnt++;
      chk("pri_retrain",
          32'({bus.link_state, bus.tx_online, bus.rx_online,
               bus.link_up}), 32'({3'd5, 3'b000}));
      chk("pri_cnt", 32'(bus.retrain_cnt), 32'(exp_cnt));
      bus.phy_ready   = 8'hFF;
      bus.retrain_req = 1'b0;
      step();
      chk("pri_single",
          32'({bus.link_state, bus.retrain_cnt}),
          32'({3'd5, 8'(exp_cnt)}));
      bus.link_en = 1'b0;
      step();
      chk("pri_idle",
          32'({bus.link_state, bus.tx_online, bus.rx_online,
               bus.link_up, bus.timeout_err}), 32'd0);

      // 300 alignment losses: counter saturates at 255.
      bus.align_timeout = 16'd0;
      bus.align_done    = 1'b1;
      bus.link_en       = 1'b1;
      wait_state(3'd4, 20, "sat_bringup");
      for (int i = 0; i < 300; i++) begin
         bus.align_done = 1'b0;
         step();
         if (exp_cnt < 255) exp_cnt++;
         chk($sformatf("loss%0d_off", i),
             32'({bus.link_state, bus.tx_online, bus.rx_online}),
             32'({3'd5, 2'b00}));
         chk($sformatf("loss%0d_cnt", i),
             32'(bus.retrain_cnt), 32'(exp_cnt));
         bus.align_done = 1'b1;
         wait_state(3'd4, 20, $sformatf("loss%0d_reup", i));
      end
      chk("sat_255", 32'(bus.retrain_cnt), 32'd255);

      // Disabled timeout: long alignment wait never errors.
      bus.link_en = 1'b0;
      step();
      bus.align_done = 1'b0;
      bus.link_en    = 1'b1;
      wait_state(3'd3, 20, "noto_align");
      do_steps(70000, 3'd3, "noto_70000");

      // Asynchronous reset while ACTIVE.
      bus.align_done = 1'b1;
      step();
      chk("ar_active", 32'(bus.link_state), 32'd4);
      @(posedge clk_wr);
      #3;
      rst_wr = 1'b1;
      #1;
      chk("ar_flags",
          32'({bus.link_state, bus.tx_online, bus.rx_online,
               bus.link_up, bus.timeout_err}), 32'd0);
      chk("ar_cnt", 32'(bus.retrain_cnt), 32'd0);
      step();
      rst_wr = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors",
               checks, errors);
      $finish;
   end
endmodule
